// File: rtl/mul12_pkg.sv
// Shared constants for the 12-bit structural multiplier slice.
// PW is the full product width, so carry-save intermediates never lose a carry.
package mul12_pkg;

  localparam int W  = 12;
  localparam int PW = 2 * W;

endpackage

// File: rtl/mul12_csa.sv
// Bitwise 3:2 carry-save compressor: three addends in, sum and carry vectors out.
// The carry vector is pre-shifted by one, so the block is self-contained.
module mul12_csa
  import mul12_pkg::*;
#(
  parameter int N = PW
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] carry_o
);

  logic [N-1:0] majority;

  assign sum_o    = a_i ^ b_i ^ c_i;
  assign majority = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

  // The product fits in N bits, so dropping the top carry leaves the result unchanged.
  assign carry_o  = {majority[N-2:0], 1'b0};

endmodule

// File: rtl/mul12.sv
// Unsigned W x W array multiplier with a combinational product and a registered copy.
// Partial products pass through a carry-save chain, and one final add resolves them.
module mul12
  import mul12_pkg::*;
#(
  parameter int W = mul12_pkg::W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     input0,
  input  logic [W-1:0]     input1,
  output logic [2*W-1:0]   output0,
  output logic [2*W-1:0]   output0_q,
  output logic             valid_q
);

  localparam int PWL = 2 * W;

  logic [PWL-1:0] pp   [W];
  logic [PWL-1:0] sumV [W-1];
  logic [PWL-1:0] carV [W-1];
  logic [PWL-1:0] output0_d;
  logic           valid_d;

  // Row i is input0 shifted by i, and it is forced to zero when multiplier bit i is clear.
  for (genvar i = 0; i < W; i++) begin : g_pp
    assign pp[i] = input1[i] ? ({{W{1'b0}}, input0} << i) : '0;
  end

  assign sumV[0] = pp[0];
  assign carV[0] = pp[1];

  for (genvar k = 0; k < W - 2; k++) begin : g_csa
    mul12_csa #(.N(PWL)) u_csa (
      .a_i     (sumV[k]),
      .b_i     (carV[k]),
      .c_i     (pp[k+2]),
      .sum_o   (sumV[k+1]),
      .carry_o (carV[k+1])
    );
  end

  assign output0   = sumV[W-2] + carV[W-2];
  assign output0_d = output0;
  assign valid_d   = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output0_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      output0_q <= output0_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_mul12.sv
// Self-checking bench for mul12: vector table, wrap sweep, random pairs and reset sequences.
// Products are predicted by the bench and checked on output0 and, one edge later, on output0_q.
module tb_mul12;

  localparam int W  = 12;
  localparam int PW = 24;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] exp;
  } vecT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  input0;
  logic [W-1:0]  input1;
  logic [PW-1:0] output0;
  logic [PW-1:0] output0_q;
  logic          valid_q;

  logic [PW-1:0] expQ [$];
  int            assertCount = 0;
  int            failCount   = 0;

  always #5 clk = ~clk;

  mul12 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .input0    (input0),
    .input1    (input1),
    .output0   (output0),
    .output0_q (output0_q),
    .valid_q   (valid_q)
  );

  // This reference uses full-width behavioural multiplication, independent of the DUT structure.
  function automatic logic [PW-1:0] refProd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    ea = {{(PW-W){1'b0}}, a};
    eb = {{(PW-W){1'b0}}, b};
    return ea * eb;
  endfunction

  task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive the operands between edges and check the combinational product.
  // After the next rising edge, the queued prediction is checked against the registered copy.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [PW-1:0] exp, input string name);
    @(negedge clk);
    input0 = a;
    input1 = b;
    #1;
    checkOutput({name, " output0"}, output0, exp);
    expQ.push_back(exp);
    @(posedge clk);
    #1;
    checkOutput({name, " output0_q"}, output0_q, expQ.pop_front());
    checkOutput({name, " valid_q"}, {{(PW-1){1'b0}}, valid_q}, 24'd1);
  endtask

  initial begin
    vecT          vecs [11];
    logic [W-1:0] sa;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           failBefore;

    vecs[0]  = '{12'h000, 12'hABC, 24'h000000};
    vecs[1]  = '{12'h001, 12'hABC, 24'h000ABC};
    vecs[2]  = '{12'h800, 12'h002, 24'h001000};
    vecs[3]  = '{12'hFFF, 12'hFFF, 24'hFFE001};
    vecs[4]  = '{12'hFF0, 12'hFF0, 24'hFE0100};
    vecs[5]  = '{12'hABC, 12'h000, 24'h000000};
    vecs[6]  = '{12'hABC, 12'h001, 24'h000ABC};
    vecs[7]  = '{12'hFFF, 12'h001, 24'h000FFF};
    vecs[8]  = '{12'h001, 12'hFFF, 24'h000FFF};
    vecs[9]  = '{12'h123, 12'h456, 24'h04EDC2};
    vecs[10] = '{12'hFFF, 12'h000, 24'h000000};

    rst_n  = 1'b0;
    input0 = 12'h123;
    input1 = 12'h456;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset output0_q", output0_q, 24'h000000);
    checkOutput("reset valid_q", {{(PW-1){1'b0}}, valid_q}, 24'd0);
    checkOutput("reset output0 live", output0, 24'h04EDC2);

    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    $display("[TB] lock-step sweep through wrap");
    sa = 12'hFF0;
    for (int i = 0; i < 32; i++) begin
      failBefore = failCount;
      applyStimulus(sa, sa, refProd(sa, sa), $sformatf("sweep %h", sa));
      if (failCount != failBefore)
        $fatal(1, "[TB] sweep stopped at operand %h", sa);
      sa = sa + 12'h001;
    end

    $display("[TB] random pairs");
    for (int i = 0; i < 20000; i++) begin
      ra = W'($urandom_range(0, 4095));
      rb = W'($urandom_range(0, 4095));
      applyStimulus(ra, rb, refProd(ra, rb), "rand");
    end

    $display("[TB] mid-operation reset");
    applyStimulus(12'h123, 12'h456, 24'h04EDC2, "prereset");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset output0_q", output0_q, 24'h000000);
    checkOutput("async reset valid_q", {{(PW-1){1'b0}}, valid_q}, 24'd0);
    checkOutput("async reset output0", output0, 24'h04EDC2);
    @(posedge clk);
    #1;
    checkOutput("held reset output0_q", output0_q, 24'h000000);
    checkOutput("held reset valid_q", {{(PW-1){1'b0}}, valid_q}, 24'd0);
    @(negedge clk);
    input0 = 12'hFFF;
    input1 = 12'hFFF;
    rst_n  = 1'b1;
    #1;
    checkOutput("release output0_q still clear", output0_q, 24'h000000);
    @(posedge clk);
    #1;
    checkOutput("release load output0_q", output0_q, 24'hFFE001);
    checkOutput("release valid_q", {{(PW-1){1'b0}}, valid_q}, 24'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
